// File: rtl/branch_resolution_unit_if.sv
// Fetch/execute-facing signal bundle of the branch resolution unit.
// The master side is the pipeline (fetch + execute); the slave side is the unit.
interface branch_resolution_unit_if #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32
);
  logic                    pred_valid;
  logic                    pred_taken;
  logic [ADDR_WIDTH-1:0]   pred_pc;
  logic [ADDR_WIDTH-1:0]   pred_target;
  logic                    pred_ready;
  logic                    res_valid;
  logic                    res_taken;
  logic [ADDR_WIDTH-1:0]   res_target;
  logic                    update_valid;
  logic                    update_taken;
  logic                    flush;
  logic [ADDR_WIDTH-1:0]   redirect_pc;
  logic                    res_error;
  logic [$clog2(DEPTH):0]  inflight_count;
  logic [31:0]             branch_count;
  logic [31:0]             mispredict_count;

  modport master (
    output pred_valid, pred_taken, pred_pc, pred_target,
    output res_valid, res_taken, res_target,
    input  pred_ready, update_valid, update_taken, flush, redirect_pc,
    input  res_error, inflight_count, branch_count, mispredict_count
  );

  modport slave (
    input  pred_valid, pred_taken, pred_pc, pred_target,
    input  res_valid, res_taken, res_target,
    output pred_ready, update_valid, update_taken, flush, redirect_pc,
    output res_error, inflight_count, branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_resolution_unit.sv
// In-order queue of predicted branches; compares each resolve against the oldest
// prediction and emits predictor updates, flush/redirect and statistics.
module branch_resolution_unit #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  branch_resolution_unit_if.slave    bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [31:0]      COUNT_MAX  = 32'hFFFF_FFFF;

  logic                  entry_taken_r  [DEPTH];
  logic [ADDR_WIDTH-1:0] entry_pc_r     [DEPTH];
  logic [ADDR_WIDTH-1:0] entry_target_r [DEPTH];

  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic                  update_valid_r;
  logic                  update_taken_r;
  logic                  flush_r;
  logic [ADDR_WIDTH-1:0] redirect_pc_r;
  logic                  res_error_r;
  logic [31:0]           branch_count_r;
  logic [31:0]           mispredict_count_r;

  logic                  pred_ready_s;
  logic                  resolve_s;
  logic                  mispredict_s;
  logic                  push_s;
  logic                  empty_res_s;
  logic                  head_taken_s;
  logic [ADDR_WIDTH-1:0] head_pc_s;
  logic [ADDR_WIDTH-1:0] head_target_s;
  logic [ADDR_WIDTH-1:0] redirect_next_s;

  assign pred_ready_s  = (count_r != FULL_COUNT);
  assign head_taken_s  = entry_taken_r[rd_ptr_r];
  assign head_pc_s     = entry_pc_r[rd_ptr_r];
  assign head_target_s = entry_target_r[rd_ptr_r];

  // Resolve classification and push qualification for this cycle.
  always_comb begin
    resolve_s       = 1'b0;
    mispredict_s    = 1'b0;
    empty_res_s     = 1'b0;
    push_s          = 1'b0;
    redirect_next_s = redirect_pc_r;
    if (bus.res_valid && (count_r != {CNT_W{1'b0}})) begin
      resolve_s = 1'b1;
      // A not-taken/not-taken match is correct regardless of target.
      if (bus.res_taken != head_taken_s) begin
        mispredict_s = 1'b1;
      end else if (bus.res_taken && (bus.res_target != head_target_s)) begin
        mispredict_s = 1'b1;
      end else begin
        mispredict_s = 1'b0;
      end
      if (bus.res_taken) begin
        redirect_next_s = bus.res_target;
      end else begin
        redirect_next_s = head_pc_s + ADDR_WIDTH'(4);
      end
    end else begin
      empty_res_s = bus.res_valid;
    end
    // Pushes arriving alongside a squash are wrong-path and dropped.
    if (bus.pred_valid && pred_ready_s && !mispredict_s) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
  end

  // Queue entry storage; contents need no reset since occupancy gates their use.
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      entry_taken_r[wr_ptr_r]  <= bus.pred_taken;
      entry_pc_r[wr_ptr_r]     <= bus.pred_pc;
      entry_target_r[wr_ptr_r] <= bus.pred_target;
    end
  end

  // Pointers, occupancy, output pulses and saturating statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r           <= {PTR_W{1'b0}};
      rd_ptr_r           <= {PTR_W{1'b0}};
      count_r            <= {CNT_W{1'b0}};
      update_valid_r     <= 1'b0;
      update_taken_r     <= 1'b0;
      flush_r            <= 1'b0;
      redirect_pc_r      <= {ADDR_WIDTH{1'b0}};
      res_error_r        <= 1'b0;
      branch_count_r     <= 32'd0;
      mispredict_count_r <= 32'd0;
    end else begin
      update_valid_r <= resolve_s;
      flush_r        <= mispredict_s;
      res_error_r    <= empty_res_s;
      redirect_pc_r  <= redirect_next_s;
      if (resolve_s) begin
        update_taken_r <= bus.res_taken;
        if (branch_count_r != COUNT_MAX) begin
          branch_count_r <= branch_count_r + 32'd1;
        end else begin
          branch_count_r <= branch_count_r;
        end
      end else begin
        update_taken_r <= update_taken_r;
        branch_count_r <= branch_count_r;
      end
      if (mispredict_s && (mispredict_count_r != COUNT_MAX)) begin
        mispredict_count_r <= mispredict_count_r + 32'd1;
      end else begin
        mispredict_count_r <= mispredict_count_r;
      end
      if (mispredict_s) begin
        wr_ptr_r <= {PTR_W{1'b0}};
        rd_ptr_r <= {PTR_W{1'b0}};
        count_r  <= {CNT_W{1'b0}};
      end else begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_W'(1);
        end else begin
          wr_ptr_r <= wr_ptr_r;
        end
        if (resolve_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_W'(1);
        end else begin
          rd_ptr_r <= rd_ptr_r;
        end
        case ({push_s, resolve_s})
          2'b10:   count_r <= count_r + CNT_W'(1);
          2'b01:   count_r <= count_r - CNT_W'(1);
          default: count_r <= count_r;
        endcase
      end
    end
  end

  assign bus.pred_ready       = pred_ready_s;
  assign bus.update_valid     = update_valid_r;
  assign bus.update_taken     = update_taken_r;
  assign bus.flush            = flush_r;
  assign bus.redirect_pc      = redirect_pc_r;
  assign bus.res_error        = res_error_r;
  assign bus.inflight_count   = count_r;
  assign bus.branch_count     = branch_count_r;
  assign bus.mispredict_count = mispredict_count_r;
endmodule
